masked_table_writer: RTL and testbench
======================================

# masked_table_writer

Runtime loader and server for one masked S-box lookup table, i.e. the write side of the fixed-content dual-port BRAM S-box tables. Accepts a stream of 16-bit beats, each carrying two table bytes, and writes them into an internal 1024×8 true-dual-port RAM using both ports per beat. Once all 1024 entries are written, it raises `table_valid` and serves two independent registered read ports with the same 10-bit address / 8-bit data / 2-cycle latency shape as the static S-box tables. This allows mask tables to be refreshed without a bitstream rebuild.

## Interface
Parameters:
- `ADDR_W`, 10: table address width; depth = 2^ADDR_W.
- `DATA_W`, 8: table entry width; a beat is 2×DATA_W.

Ports:
- `clk`  input  1  single clock.
- `rst`  input  1  synchronous, active-low reset.
- `start`  input  1  load request; sampled every cycle.
- `DIN`  input  16  beat; `DIN[7:0]` goes to address 2k, `DIN[15:8]` goes to address 2k+1.
- `DIN_valid`  input  1  beat present.
- `DIN_ready`  output  1  high only in LOAD.
- `ADDRA`, `ADDRB`  input  10  read addresses.
- `EN`  input  1  read enable and output-register enable for both ports.
- `DOA`, `DOB`  output  8  read data.
- `table_valid`  output  1  table completely loaded.
- `load_done`  output  1  one-cycle pulse at load completion.

## Operation
- States:
  - IDLE: reset state; table invalid.
  - LOAD: accepting beats.
  - READY: table valid.
- Transitions:
  - IDLE→LOAD on `start`.
  - LOAD→READY on acceptance of beat 511.
  - READY→LOAD on `start`.
  - LOAD→LOAD on `start`: the beat counter is cleared to 0. A beat offered in the same cycle is not accepted.
- Beat accepted when `DIN_valid && DIN_ready`. The 9-bit beat counter k selects the addresses: port A writes address {k,0} with `DIN[7:0]`, port B writes {k,1} with `DIN[15:8]`. Then k increments.
- `table_valid` = (state == READY). `load_done` is high in the first cycle of READY only.
- Read gating: in a cycle with `EN`=1 and `table_valid`=0, the RAM read is issued, but the data it produces at the outputs is replaced by 0. `EN`=0 means both pipeline stages hold.
- In LOAD, both RAM ports are used for writes, so external reads are ignored (they produce 0 per the gating above).
- Reset:
  - state=IDLE, k=0.
  - `DIN_ready`=0, `table_valid`=0, `load_done`=0.
  - `DOA`=`DOB`=0, and the output pipeline registers are cleared.
  - RAM contents are not cleared.
- Reset in mid-load abandons the partial table; a new `start` is required.

## Timing
- `start` in cycle t: LOAD and `DIN_ready`=1 from t+1.
- A full back-to-back load takes 512 beats. Beat 511 accepted in cycle t gives READY, `table_valid`=1 and `load_done`=1 at t+1, and `load_done`=0 at t+2.
- Read latency is 2 cycles: address sampled at t with `EN`=1 gives data on `DOA`/`DOB` at t+2, provided `EN`=1 at t+1.
- The first valid read address may be presented in cycle t+1, where t is the acceptance cycle of beat 511. Its data appears at t+3.
- `start` in READY at cycle t: `table_valid`=0 at t+1. Reads sampled at t still return real data; reads sampled from t+1 onward return 0.
- Address collision A=B on reads is legal; both ports return the same byte.

## Structure
- Package `masked_table_pkg` holds:
  - `ADDR_W` and `DATA_W` defaults, and `BEATS` = 2^(ADDR_W-1).
  - The state enum {IDLE, LOAD, READY}.
- Sub-module `tdp_ram_1024x8`: inferred true-dual-port RAM with write-first behaviour, read register plus optional output register (two read stages, matching the static tables), and a shared enable. The top level holds the FSM, the beat counter, the write/read port muxing and the validity gating.

## Test plan
- Reset then 512 back-to-back beats with `DIN` = {2k+1, 2k} mod 256 → `load_done` pulses exactly once, one cycle after beat 511. A read of A=0x3FF, B=0x000 returns `DOA`=0xFF, `DOB`=0x00 two cycles later.
- Random `DIN_valid` gaps during load → exactly 512 accepted beats. The full 1024-address readback matches the stream byte-for-byte.
- `start` asserted after beat 200 → counter restarts at 0 and `table_valid` stays 0. After a full reload, address 0 holds the new stream's byte, not the old one.
- Reads with `EN`=1 during LOAD and in IDLE → `DOA`=`DOB`=0. The `EN`=0 hold check: hold `EN` low for 3 cycles in READY → outputs frozen at their last value.
- `rst` low for one cycle mid-load at beat 300 → all outputs 0 the next cycle and `DIN_ready`=0. Only `start` resumes loading, from k=0.
- `start` in READY → `table_valid` falls in the next cycle. A read issued in the same cycle as `start` still returns table data; a read one cycle later returns 0.

Source files
------------

// File: rtl/masked_table_pkg.sv
// Shared sizing and state encoding for the runtime-loadable masked S-box table.
package masked_table_pkg;

   localparam int TBL_ADDR_W = 10;
   localparam int TBL_DATA_W = 8;
   localparam int BEATS      = 2 ** (TBL_ADDR_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } state_t;

endpackage

// File: rtl/tdp_ram_1024x8.sv
// True-dual-port block RAM, write-first, with a read register and an optional
// output register per port; one shared enable advances both read pipelines.
module tdp_ram_1024x8
   import masked_table_pkg::*;
#(
   parameter int ADDR_W  = TBL_ADDR_W,
   parameter int DATA_W  = TBL_DATA_W,
   parameter bit OUT_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] din_a,
   input  logic [DATA_W-1:0] din_b,
   output logic [DATA_W-1:0] dout_a,
   output logic [DATA_W-1:0] dout_b
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [1:0]          we_w;
   logic [2*ADDR_W-1:0] addr_w;
   logic [2*DATA_W-1:0] din_w;
   logic [2*DATA_W-1:0] dout_w;

   assign we_w   = {we_b, we_a};
   assign addr_w = {addr_b, addr_a};
   assign din_w  = {din_b, din_a};
   assign dout_a = dout_w[DATA_W-1:0];
   assign dout_b = dout_w[2*DATA_W-1:DATA_W];

   // Array contents are never reset so the tool can map this onto block RAM.
   always_ff @(posedge clk) begin
      if (we_a) begin
         mem[addr_a] <= din_a;
      end
      if (we_b) begin
         mem[addr_b] <= din_b;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_W-1:0] rd1_q;

         always_ff @(posedge clk) begin
            if (!rst) begin
               rd1_q <= '0;
            end else if (en) begin
               rd1_q <= we_w[gi] ? din_w[gi*DATA_W +: DATA_W]
                                 : mem[addr_w[gi*ADDR_W +: ADDR_W]];
            end
         end

         if (OUT_REG) begin : g_oreg
            logic [DATA_W-1:0] rd2_q;

            always_ff @(posedge clk) begin
               if (!rst) begin
                  rd2_q <= '0;
               end else if (en) begin
                  rd2_q <= rd1_q;
               end
            end

            assign dout_w[gi*DATA_W +: DATA_W] = rd2_q;
         end else begin : g_noreg
            assign dout_w[gi*DATA_W +: DATA_W] = rd1_q;
         end
      end
   endgenerate

endmodule

// File: rtl/masked_table_writer.sv
// Streams 2-byte beats into a dual-port table, then serves two gated
// 2-cycle read ports once every entry has been written.
module masked_table_writer
   import masked_table_pkg::*;
#(
   parameter int ADDR_W = TBL_ADDR_W,
   parameter int DATA_W = TBL_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [2*DATA_W-1:0] DIN,
   input  logic                DIN_valid,
   output logic                DIN_ready,
   input  logic [ADDR_W-1:0]   ADDRA,
   input  logic [ADDR_W-1:0]   ADDRB,
   input  logic                EN,
   output logic [DATA_W-1:0]   DOA,
   output logic [DATA_W-1:0]   DOB,
   output logic                table_valid,
   output logic                load_done
);

   localparam int K_W = ADDR_W - 1;

   state_t            state_q, state_d;
   logic [K_W-1:0]    k_q, k_d;
   logic              load_done_q, load_done_d;
   logic              vld1_q, vld2_q;
   logic              accept;
   logic              last_beat;
   logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
   logic [DATA_W-1:0] ram_doa, ram_dob;

   // A start in LOAD restarts the count, so a beat offered alongside it is dropped.
   assign accept    = (state_q == LOAD) && DIN_valid && !start;
   assign last_beat = (k_q == '1);

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      load_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               k_d     = '0;
            end
         end
         LOAD: begin
            if (start) begin
               k_d = '0;
            end else if (accept) begin
               k_d = k_q + 1'b1;
               if (last_beat) begin
                  state_d     = READY;
                  load_done_d = 1'b1;
               end
            end
         end
         READY: begin
            if (start) begin
               state_d = LOAD;
               k_d     = '0;
            end
         end
         default: begin
            state_d = IDLE;
            k_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         load_done_q <= 1'b0;
         vld1_q      <= 1'b0;
         vld2_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         load_done_q <= load_done_d;
         // Validity is captured with the address, so it tracks the sampling cycle.
         if (EN) begin
            vld1_q <= (state_q == READY);
            vld2_q <= vld1_q;
         end
      end
   end

   always_comb begin
      ram_addr_a = ADDRA;
      ram_addr_b = ADDRB;
      if (state_q == LOAD) begin
         ram_addr_a = {k_q, 1'b0};
         ram_addr_b = {k_q, 1'b1};
      end
   end

   tdp_ram_1024x8 #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .OUT_REG (1'b1)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .en     (EN),
      .we_a   (accept),
      .we_b   (accept),
      .addr_a (ram_addr_a),
      .addr_b (ram_addr_b),
      .din_a  (DIN[DATA_W-1:0]),
      .din_b  (DIN[2*DATA_W-1:DATA_W]),
      .dout_a (ram_doa),
      .dout_b (ram_dob)
   );

   assign DIN_ready   = (state_q == LOAD);
   assign table_valid = (state_q == READY);
   assign load_done   = load_done_q;
   assign DOA         = vld2_q ? ram_doa : '0;
   assign DOB         = vld2_q ? ram_dob : '0;

endmodule

// File: tb/tb_masked_table_writer.sv
// Directed bench for masked_table_writer: loads, restarts, resets and gated reads.
module tb_masked_table_writer;
   import masked_table_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] DIN;
   logic        DIN_valid;
   logic        DIN_ready;
   logic [9:0]  ADDRA;
   logic [9:0]  ADDRB;
   logic        EN;
   logic [7:0]  DOA;
   logic [7:0]  DOB;
   logic        table_valid;
   logic        load_done;

   int          total = 0;
   int          bad   = 0;
   int          p;
   int          q;
   logic [7:0]  model [1024];

   masked_table_writer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .DIN         (DIN),
      .DIN_valid   (DIN_valid),
      .DIN_ready   (DIN_ready),
      .ADDRA       (ADDRA),
      .ADDRB       (ADDRB),
      .EN          (EN),
      .DOA         (DOA),
      .DOB         (DOB),
      .table_valid (table_valid),
      .load_done   (load_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] bval(input int a, input logic [7:0] off);
      return 8'(a) + off;
   endfunction

   // Offers beats k0..k0+n-1 (optionally with idle gaps) and records them in the model.
   task automatic load_beats(input int k0, input int n, input logic [7:0] off,
                             input bit gaps, output int pulses);
      pulses = 0;
      for (int k = k0; k < k0 + n; k++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            DIN_valid = 1'b0;
            DIN       = 16'hDEAD;
            repeat ($urandom_range(1, 3)) begin
               tick();
               if (load_done === 1'b1) pulses++;
            end
         end
         DIN       = {bval(2*k+1, off), bval(2*k, off)};
         DIN_valid = 1'b1;
         tick();
         if (load_done === 1'b1) pulses++;
         model[2*k]   = bval(2*k, off);
         model[2*k+1] = bval(2*k+1, off);
      end
      DIN_valid = 1'b0;
      $display("load beats %0d..%0d off=%02h pulses=%0d", k0, k0 + n - 1, off, pulses);
   endtask

   task automatic rd(input logic [9:0] a, input logic [9:0] b, input string tag);
      ADDRA = a;
      ADDRB = b;
      EN    = 1'b1;
      tick();
      tick();
      chk({tag, "_A"}, DOA, model[a]);
      chk({tag, "_B"}, DOB, model[b]);
      $display("read %s A=%03h DOA=%02h B=%03h DOB=%02h", tag, a, DOA, b, DOB);
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      DIN       = '0;
      DIN_valid = 1'b0;
      ADDRA     = '0;
      ADDRB     = '0;
      EN        = 1'b0;
      tick();
      tick();
      chk("rst_ready", DIN_ready, 0);
      chk("rst_tv", table_valid, 0);
      chk("rst_done", load_done, 0);
      chk("rst_doa", DOA, 0);
      chk("rst_dob", DOB, 0);
      $display("reset ready=%0b tv=%0b done=%0b", DIN_ready, table_valid, load_done);
      rst = 1'b1;

      // reads in IDLE are gated to zero
      ADDRA = 10'h005;
      ADDRB = 10'h006;
      EN    = 1'b1;
      repeat (3) tick();
      chk("idle_doa", DOA, 0);
      chk("idle_dob", DOB, 0);
      $display("idle read DOA=%02h DOB=%02h", DOA, DOB);

      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_ready", DIN_ready, 1);
      chk("start_tv", table_valid, 0);

      // first load, with reads enabled during LOAD
      load_beats(0, 100, 8'h00, 1'b0, p);
      chk("load_doa", DOA, 0);
      chk("load_dob", DOB, 0);
      load_beats(100, BEATS - 100, 8'h00, 1'b0, q);
      chk("load1_tv", table_valid, 1);
      chk("load1_done", load_done, 1);
      chk("load1_ready", DIN_ready, 0);
      chk("load1_pulses", p + q, 1);

      ADDRA = 10'h3FF;
      ADDRB = 10'h000;
      EN    = 1'b1;
      tick();
      chk("done_fall", load_done, 0);
      tick();
      chk("first_doa", DOA, 8'hFF);
      chk("first_dob", DOB, 8'h00);
      $display("first read DOA=%02h DOB=%02h", DOA, DOB);

      // EN low freezes both pipelines
      ADDRA = 10'h010;
      ADDRB = 10'h011;
      EN    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_doa", DOA, 8'hFF);
         chk("hold_dob", DOB, 8'h00);
      end
      rd(10'h010, 10'h011, "after_hold");
      rd(10'h077, 10'h077, "collision");

      // start in READY: same-cycle read keeps data, next read is gated
      ADDRA = 10'h020;
      ADDRB = 10'h021;
      EN    = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rs_tv", table_valid, 0);
      chk("rs_ready", DIN_ready, 1);
      ADDRA = 10'h022;
      ADDRB = 10'h023;
      tick();
      chk("rs_same_doa", DOA, 8'h20);
      chk("rs_same_dob", DOB, 8'h21);
      tick();
      chk("rs_next_doa", DOA, 0);
      chk("rs_next_dob", DOB, 0);

      // partial load, then restart from k=0 with a beat offered alongside start
      load_beats(0, 201, 8'h40, 1'b0, p);
      chk("partial_pulses", p, 0);
      start     = 1'b1;
      DIN       = 16'hEEEE;
      DIN_valid = 1'b1;
      tick();
      start     = 1'b0;
      DIN_valid = 1'b0;
      chk("restart_tv", table_valid, 0);
      chk("restart_ready", DIN_ready, 1);
      load_beats(0, BEATS, 8'h80, 1'b1, p);
      chk("reload_pulses", p, 1);
      chk("reload_tv", table_valid, 1);
      tick();
      for (int i = 0; i < BEATS; i++) begin
         rd(10'(2*i), 10'(2*i+1), "readback");
      end

      // reset in mid-load abandons the table
      start = 1'b1;
      tick();
      start = 1'b0;
      load_beats(0, 300, 8'hC0, 1'b0, p);
      EN    = 1'b1;
      ADDRA = 10'h000;
      rst   = 1'b0;
      tick();
      rst   = 1'b1;
      chk("mid_rst_ready", DIN_ready, 0);
      chk("mid_rst_tv", table_valid, 0);
      chk("mid_rst_done", load_done, 0);
      chk("mid_rst_doa", DOA, 0);
      chk("mid_rst_dob", DOB, 0);
      DIN       = 16'h5A5A;
      DIN_valid = 1'b1;
      tick();
      tick();
      chk("no_start_ready", DIN_ready, 0);
      chk("no_start_tv", table_valid, 0);
      DIN_valid = 1'b0;

      start = 1'b1;
      tick();
      start = 1'b0;
      load_beats(0, BEATS, 8'h11, 1'b0, p);
      chk("resume_pulses", p, 1);
      tick();
      rd(10'h000, 10'h001, "resume_lo");
      rd(10'h258, 10'h3FF, "resume_hi");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
